// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a one-cycle CPU access into the req/grant/as/rdy handshake, 3+ cycles after the request.
// cpu_busy stalls the pipeline until rdy; BUS_MASTER_TIMEOUT_EN adds an abort with bus_err when rdy never arrives.
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_stall,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy,
  output logic              bus_err
);

  typedef enum logic [2:0] {IDLE, REQ, ACCESS, WAIT_RDY, HOLD} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rd_buf;
  logic              accept, done, abort;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;
  logic       tmo_hit;

  // The abort cycle is the WAIT_RDY cycle in which err_q is already visible.
  assign tmo_hit = (state == WAIT_RDY) && !bus_rdy && !err_q && (tmo_cnt == 8'(TIMEOUT - 1));
  assign abort   = (state == WAIT_RDY) && err_q;
  assign bus_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if ((state == REQ) && bus_grnt)
        tmo_cnt <= '0;
      else if ((state == WAIT_RDY) && !bus_rdy && !err_q)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign accept = (state == IDLE) && cpu_req && !cpu_flush;
  assign done   = (state == WAIT_RDY) && bus_rdy && !abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cpu_busy    = 1'b0;
    cpu_rd_data = rd_buf;
    case (state)
      IDLE: begin
        if (accept) begin
          cpu_busy  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        cpu_busy = 1'b1;
        if (bus_grnt) state_nxt = ACCESS;
      end
      ACCESS: begin
        cpu_busy  = 1'b1;
        state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (abort) begin
          cpu_rd_data = '0;
          state_nxt   = cpu_stall ? HOLD : IDLE;
        end else if (bus_rdy) begin
          cpu_rd_data = bus_rd_data;
          state_nxt   = cpu_stall ? HOLD : IDLE;
        end else begin
          cpu_busy = 1'b1;
        end
      end
      HOLD: begin
        if (!cpu_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-side registers: latched on accept, held through the access, parked at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req     <= 1'b0;
      bus_as      <= 1'b0;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      bus_as <= (state == REQ) && bus_grnt;
      if (accept) begin
        bus_req     <= 1'b1;
        bus_addr    <= cpu_addr;
        bus_rw      <= cpu_rw;
        bus_wr_data <= cpu_wr_data;
      end else if (done || abort) begin
        bus_req     <= 1'b0;
        bus_rw      <= 1'b1;
        bus_addr    <= '0;
        bus_wr_data <= '0;
      end
`ifdef BUS_MASTER_TIMEOUT_EN
      if (tmo_hit) bus_req <= 1'b0;
`endif
      if (done && bus_rw) rd_buf <= bus_rd_data;
    end
  end

endmodule
